// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser
// Keeps a live count for each denomination. A change request is first planned
// with a greedy largest-first pass over a shadow copy of the inventory, so an
// infeasible request never touches the real counts. A feasible plan is then
// streamed out one coin per dispenser handshake, decrementing the inventory.
module vm_change_dispenser #(
    parameter int N_DENOM  = 15,
    parameter int AMOUNT_W = 17,
    parameter int CNT_W    = 8,
    parameter logic [N_DENOM*AMOUNT_W-1:0] DENOM_VAL = {
        17'd50000, 17'd20000, 17'd10000, 17'd5000, 17'd2000,
        17'd1000,  17'd500,   17'd200,   17'd100,  17'd50,
        17'd25,    17'd10,    17'd5,     17'd2,    17'd1},
    parameter int INIT_CNT = 100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [AMOUNT_W-1:0]        req_amount,
    output logic                       req_ready,
    output logic                       done,
    output logic                       ok,
    output logic                       coin_valid,
    output logic [$clog2(N_DENOM)-1:0] coin_idx,
    input  logic                       coin_ready,
    input  logic                       dep_valid,
    input  logic [$clog2(N_DENOM)-1:0] dep_idx,
    input  logic                       load_valid,
    input  logic [$clog2(N_DENOM)-1:0] load_idx,
    input  logic [CNT_W-1:0]           load_cnt,
    input  logic [$clog2(N_DENOM)-1:0] rd_idx,
    output logic [CNT_W-1:0]           rd_cnt
);

    localparam int IW = $clog2(N_DENOM);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CHECK    = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IW-1:0]    IDX_LAST = IW'(N_DENOM - 1);

    logic [1:0]          state_r;
    logic [IW-1:0]       idx_r;
    logic [AMOUNT_W-1:0] rem_r;
    logic                ok_r;
    logic [CNT_W-1:0]    cnt_r    [N_DENOM];
    logic [CNT_W-1:0]    shadow_r [N_DENOM];
    logic [CNT_W-1:0]    plan_r   [N_DENOM];

    logic [AMOUNT_W-1:0] val_s    [N_DENOM];
    logic [CNT_W-1:0]    cnt_upd_s[N_DENOM];
    logic                last_s;
    logic                take_s;

    // Unpack the denomination table; index 0 sits in the most significant slot.
    for (genvar g = 0; g < N_DENOM; g++) begin : g_val
        assign val_s[g] = DENOM_VAL[(N_DENOM-1-g)*AMOUNT_W +: AMOUNT_W];
    end

    assign last_s     = (idx_r == IDX_LAST);
    assign take_s     = (rem_r >= val_s[idx_r]) && (shadow_r[idx_r] != '0);
    assign req_ready  = (state_r == ST_IDLE);
    assign done       = (state_r == ST_DONE);
    assign ok         = ok_r;
    assign coin_valid = (state_r == ST_DISPENSE) && (plan_r[idx_r] != '0);
    assign coin_idx   = idx_r;
    assign rd_cnt     = cnt_r[rd_idx];

    // Idle-time inventory update: load overrides deposit, deposit saturates.
    always_comb begin
        for (int k = 0; k < N_DENOM; k++) begin
            cnt_upd_s[k] = cnt_r[k];
            if ((state_r == ST_IDLE) && load_valid && (load_idx == IW'(k))) begin
                cnt_upd_s[k] = load_cnt;
            end else if ((state_r == ST_IDLE) && dep_valid && (dep_idx == IW'(k))
                         && (cnt_r[k] != CNT_MAX)) begin
                cnt_upd_s[k] = cnt_r[k] + CNT_W'(1);
            end else begin
                cnt_upd_s[k] = cnt_r[k];
            end
        end
    end

    // Control FSM with plan/shadow/inventory bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            rem_r   <= '0;
            ok_r    <= 1'b0;
            for (int k = 0; k < N_DENOM; k++) begin
                cnt_r[k]    <= CNT_W'(INIT_CNT);
                shadow_r[k] <= '0;
                plan_r[k]   <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= cnt_upd_s;
                    if (req_valid) begin
                        // Snapshot includes this cycle's deposit/load.
                        rem_r    <= req_amount;
                        shadow_r <= cnt_upd_s;
                        for (int k = 0; k < N_DENOM; k++) begin
                            plan_r[k] <= '0;
                        end
                        idx_r   <= '0;
                        ok_r    <= 1'b0;
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (rem_r == '0) begin
                        idx_r   <= '0;
                        state_r <= ST_DISPENSE;
                    end else if (take_s) begin
                        shadow_r[idx_r] <= shadow_r[idx_r] - CNT_W'(1);
                        plan_r[idx_r]   <= plan_r[idx_r] + CNT_W'(1);
                        rem_r           <= rem_r - val_s[idx_r];
                    end else if (last_s) begin
                        ok_r    <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                ST_DISPENSE: begin
                    if (plan_r[idx_r] == '0) begin
                        if (last_s) begin
                            ok_r    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end else if (coin_ready) begin
                        plan_r[idx_r] <= plan_r[idx_r] - CNT_W'(1);
                        cnt_r[idx_r]  <= cnt_r[idx_r] - CNT_W'(1);
                        if (last_s && (plan_r[idx_r] == CNT_W'(1))) begin
                            ok_r    <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Scoreboard bench for vm_change_dispenser: a greedy change model computes the
// expected coin stream and result per request; a monitor acting as the coin
// dispenser pops and compares whatever the DUT presents.
module tb_vm_change_dispenser;
    localparam int N  = 15;
    localparam int AW = 17;
    localparam int CW = 8;
    localparam int IW = 4;

    int dv [N] = '{50000, 20000, 10000, 5000, 2000, 1000, 500, 200, 100, 50, 25, 10, 5, 2, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [AW-1:0] req_amount;
    logic          req_ready;
    logic          done;
    logic          ok;
    logic          coin_valid;
    logic [IW-1:0] coin_idx;
    logic          coin_ready;
    logic          dep_valid;
    logic [IW-1:0] dep_idx;
    logic          load_valid;
    logic [IW-1:0] load_idx;
    logic [CW-1:0] load_cnt;
    logic [IW-1:0] rd_idx;
    logic [CW-1:0] rd_cnt;

    vm_change_dispenser dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .done(done), .ok(ok),
        .coin_valid(coin_valid), .coin_idx(coin_idx), .coin_ready(coin_ready),
        .dep_valid(dep_valid), .dep_idx(dep_idx),
        .load_valid(load_valid), .load_idx(load_idx), .load_cnt(load_cnt),
        .rd_idx(rd_idx), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int inv [N];
    int coin_q [$];
    int res_q [$];
    bit mon_en = 1'b0;
    int stall_n = 0;
    int ready_pct = 100;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Dispenser model + scoreboard monitor.
    initial begin
        bit prev_pend;
        int prev_idx;
        int exp_v;
        prev_pend = 1'b0;
        prev_idx  = 0;
        coin_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                coin_ready = 1'b0;
                prev_pend  = 1'b0;
            end else begin
                if (done) begin
                    if (res_q.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        exp_v = res_q.pop_front();
                        check("done_ok", ok, exp_v);
                    end
                end
                if (prev_pend) begin
                    check("coin_hold_valid", coin_valid, 1);
                    check("coin_hold_idx", coin_idx, prev_idx);
                end
                if (coin_valid) begin
                    if (stall_n > 0) begin
                        coin_ready = 1'b0;
                        stall_n--;
                    end else begin
                        coin_ready = ($urandom_range(0, 99) < ready_pct);
                    end
                    if (coin_ready) begin
                        if (coin_q.size() == 0) check("unexpected_coin", 1, 0);
                        else begin
                            exp_v = coin_q.pop_front();
                            check("coin_idx", coin_idx, exp_v);
                        end
                    end
                    prev_pend = !coin_ready;
                    prev_idx  = coin_idx;
                end else begin
                    coin_ready = ($urandom_range(0, 1) == 1);
                    prev_pend  = 1'b0;
                end
            end
        end
    end

    task automatic chk_inv();
        for (int k = 0; k < N; k++) begin
            rd_idx = IW'(k);
            #1;
            check($sformatf("rd_cnt[%0d]", k), rd_cnt, inv[k]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_dep(input int idx);
        dep_valid = 1'b1;
        dep_idx   = IW'(idx);
        if (inv[idx] < 255) inv[idx]++;
        @(posedge clk);
        #1;
        dep_valid = 1'b0;
    endtask

    task automatic do_load(input int idx, input int v);
        load_valid = 1'b1;
        load_idx   = IW'(idx);
        load_cnt   = CW'(v);
        inv[idx]   = v;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    // Greedy largest-first plan with plain arithmetic; pushes expectations.
    task automatic start_req(input int amt, input bit cap_dep, input int cap_idx);
        int n;
        int rem;
        int take [N];
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 0, 1);
        if (cap_dep) begin
            dep_valid = 1'b1;
            dep_idx   = IW'(cap_idx);
            if (inv[cap_idx] < 255) inv[cap_idx]++;
        end
        rem = amt;
        for (int k = 0; k < N; k++) begin
            take[k] = rem / dv[k];
            if (take[k] > inv[k]) take[k] = inv[k];
            rem -= take[k] * dv[k];
        end
        if (rem == 0) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < take[k]; j++) coin_q.push_back(k);
                inv[k] -= take[k];
            end
            res_q.push_back(1);
        end else begin
            res_q.push_back(0);
        end
        req_valid  = 1'b1;
        req_amount = AW'(amt);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        dep_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, input bit dep_during);
        lat = 0;
        dep_valid = dep_during;
        dep_idx   = '0;
        while (!done && lat < 20000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        dep_valid = 1'b0;
        if (!done) check("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int amt);
        int lat;
        start_req(amt, 1'b0, 0);
        wait_done(lat, 1'b0);
    endtask

    initial begin
        int lat;
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_amount = '0;
        dep_valid = 1'b0; dep_idx = '0; load_valid = 1'b0; load_idx = '0;
        load_cnt = '0; rd_idx = '0;
        for (int k = 0; k < N; k++) inv[k] = 100;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_ok", ok, 0);
        check("rst_coin_valid", coin_valid, 0);
        check("rst_coin_idx", coin_idx, 0);
        rst_n = 1'b1;
        chk_inv();
        mon_en = 1'b1;

        // 875 -> 500,200,100,50,25
        do_req(875);
        chk_inv();

        // 500 with no 500s -> 200,200,100
        do_load(6, 0);
        do_req(500);
        chk_inv();

        // infeasible: only one 500 in stock, ask 300
        for (int k = 0; k < N; k++) do_load(k, (k == 6) ? 1 : 0);
        start_req(300, 1'b0, 0);
        wait_done(lat, 1'b0);
        check("infeasible_latency", lat, 15);
        chk_inv();

        // amount 0: one CHECK decision plus N skip cycles
        start_req(0, 1'b0, 0);
        wait_done(lat, 1'b0);
        check("zero_latency", lat, 16);

        // stalled dispenser: coin 13 must hold, then 14
        do_load(13, 5);
        do_load(14, 5);
        stall_n = 5;
        do_req(3);
        chk_inv();

        // deposit saturation and load-beats-deposit
        do_load(14, 100);
        for (int j = 0; j < 200; j++) do_dep(14);
        dep_valid = 1'b1; dep_idx = 4'd3; load_valid = 1'b1; load_idx = 4'd3; load_cnt = 8'd7;
        inv[3] = 7;
        @(posedge clk);
        #1;
        dep_valid = 1'b0; load_valid = 1'b0;
        chk_inv();

        // deposits while busy are ignored; deposit with request is snapshotted
        for (int k = 0; k < N; k++) do_load(k, 10);
        stall_n = 4;
        start_req(875, 1'b0, 0);
        wait_done(lat, 1'b1);
        do_load(6, 0);
        start_req(500, 1'b1, 6);
        wait_done(lat, 1'b0);
        chk_inv();

        // randomized traffic
        ready_pct = 60;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, N-1), $urandom_range(0, 20));
            if ($urandom_range(0, 2) == 0) do_dep($urandom_range(0, N-1));
            start_req(($urandom_range(0, 4) == 0) ? $urandom_range(0, 120000) : $urandom_range(0, 3000),
                      ($urandom_range(0, 4) == 0), $urandom_range(0, N-1));
            wait_done(lat, ($urandom_range(0, 3) == 0));
            if (r % 8 == 0) chk_inv();
        end
        chk_inv();
        ready_pct = 100;

        // reset in the middle of dispensing
        for (int k = 0; k < N; k++) do_load(k, 10);
        stall_n = 1000;
        start_req(875, 1'b0, 0);
        n = 0;
        while (!coin_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_coin_seen", coin_valid, 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_coin_valid", coin_valid, 0);
        check("midrst_done", done, 0);
        rst_n = 1'b1;
        stall_n = 0;
        coin_q.delete();
        res_q.delete();
        for (int k = 0; k < N; k++) inv[k] = 100;
        chk_inv();
        mon_en = 1'b1;
        do_req(123);
        chk_inv();

        repeat (3) @(posedge clk);
        check("coin_q_empty", coin_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
